// File: rtl/apb_master.sv
// APB initiator bridging the core's single-request data port to NUM_SLAVES
// peripherals. Decodes 4 KB windows at 0x1000_0000 and aborts on miss or timeout.
module apb_master #(
  parameter int NUM_SLAVES = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req,
  input  logic                       write,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       ready,
  output logic                       err,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  // Counter never exceeds TIMEOUT-1 because ACCESS is left at that value.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t                  state;
  logic [NUM_SLAVES-1:0]   sel_oh;
  logic [CNT_W-1:0]        cnt;

  logic [NUM_SLAVES-1:0]   dec_oh;
  logic                    dec_hit;
  logic [31:0]             prdata_sel;
  logic                    pready_sel;

  always_comb begin
    dec_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      dec_oh[i] = (addr[15:12] == 4'(i));
  end

  assign dec_hit = (addr[31:16] == 16'h1000) && (|dec_oh);

  // Response path is muxed by the latched one-hot select, so other slaves'
  // PREADY/PRDATA can never complete or corrupt the current transfer.
  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_oh[i])
        prdata_sel = prdata_sel | PRDATA[32*i +: 32];
  end

  assign pready_sel = |(PREADY & sel_oh);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      sel_oh  <= '0;
      cnt     <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PENABLE <= 1'b0;
      PSEL    <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready   <= 1'b0;
          err     <= 1'b0;
          PSEL    <= '0;
          PENABLE <= 1'b0;
          if (req) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            sel_oh <= dec_oh;
            if (dec_hit) begin
              PSEL  <= dec_oh;
              cnt   <= '0;
              state <= SETUP;
            end else begin
              state <= ERROR;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (pready_sel) begin
            rdata   <= PWRITE ? 32'h0 : prdata_sel;
            ready   <= 1'b1;
            err     <= 1'b0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata   <= '0;
            ready   <= 1'b1;
            err     <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
        end

        ERROR: begin
          rdata <= '0;
          ready <= 1'b1;
          err   <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level timeline model plus per-cycle compare,
// directed transfers and literal latency/data checks.
module tb_apb_master;

  localparam int NS  = 5;
  localparam int TMO = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic            req, write;
  logic [31:0]     addr, wdata;
  logic [31:0]     rdata;
  logic            ready, err;
  logic [31:0]     PADDR;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic            PENABLE;
  logic [NS-1:0]   PSEL;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  apb_master #(.NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [NS-1:0] psel;
    logic          pen, rdy, err, xfer, pwrite;
    logic [31:0]   rdata, paddr, pwdata;
  } exp_t;

  exp_t exp_tbl [int];

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  chk_en = 0;

  int            req_cyc, rdy_cyc, pen_cnt;
  logic [NS-1:0] seen_psel;
  logic [31:0]   rdata_rdy;
  logic          err_rdy;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Per-cycle comparison against the timeline model; unscheduled cycles must be idle.
  always @(negedge PCLK) begin
    exp_t e;
    if (chk_en && !PRESET) begin
      e = '{default: '0};
      if (exp_tbl.exists(cyc)) e = exp_tbl[cyc];
      check("psel", 32'(PSEL), 32'(e.psel));
      check("penable", 32'(PENABLE), 32'(e.pen));
      check("ready", 32'(ready), 32'(e.rdy));
      check("err", 32'(err), 32'(e.err));
      if (e.rdy) check("rdata", rdata, e.rdata);
      if (e.xfer) begin
        check("paddr", PADDR, e.paddr);
        check("pwrite", 32'(PWRITE), 32'(e.pwrite));
        check("pwdata", PWDATA, e.pwdata);
      end
      seen_psel = seen_psel | PSEL;
      if (PENABLE) pen_cnt++;
      if (ready) begin
        rdy_cyc   = cyc;
        rdata_rdy = rdata;
        err_rdy   = err;
      end
    end
  end

  task automatic set_background;
    for (int s = 0; s < NS; s++) PRDATA[32*s +: 32] = 32'hB000_0000 + 32'(s);
  endtask

  // wt: ACCESS cycles the slave waits before PREADY (<0 = never).
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int wt, input logic [31:0] srd, input bit spur);
    int c, n, r, idx;
    bit hit, done;
    exp_t e;
    @(posedge PCLK); #1;
    c = cyc;
    req = 1'b1; write = wr; addr = a; wdata = wd;
    idx = int'(a[15:12]);
    hit = (a[31:16] == 16'h1000) && (idx < NS);
    set_background();
    if (hit) PRDATA[32*idx +: 32] = srd;
    req_cyc = c; rdy_cyc = -1; pen_cnt = 0; seen_psel = '0;
    e = '{default: '0};
    if (!hit) begin
      r = c + 2;
      e.rdy = 1'b1; e.err = 1'b1;
      exp_tbl[r] = e;
    end else begin
      done = (wt >= 0) && (wt < TMO);
      n = done ? wt + 1 : TMO;
      r = c + 2 + n;
      e.psel = NS'(1 << idx); e.xfer = 1'b1;
      e.paddr = a; e.pwrite = wr; e.pwdata = wd;
      for (int k = c + 1; k <= c + 1 + n; k++) begin
        e.pen = (k != c + 1);
        exp_tbl[k] = e;
      end
      e = '{default: '0};
      e.rdy = 1'b1; e.err = !done;
      e.rdata = (done && !wr) ? srd : 32'h0;
      exp_tbl[r] = e;
    end
    for (int k = c + 1; k <= r; k++) begin
      @(posedge PCLK); #1;
      addr = ~a; wdata = ~wd; write = ~wr;
      PREADY = '0;
      if (hit && wt >= 0 && k == c + 2 + wt) PREADY[idx] = 1'b1;
      if (spur && k == c + 2) PREADY[3] = 1'b1;
      if (k == r) begin
        req = 1'b0;
        PREADY = '0;
      end
    end
    @(negedge PCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = '0; PRDATA = '0;
    set_background();
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    PRESET = 1'b0;
    chk_en = 1'b1;

    // Store to slave 4, PREADY one cycle into ACCESS
    xfer(1'b1, 32'h1000_4008, 32'h0000_0041, 1, 32'h0, 1'b0);
    check("t1_latency", 32'(rdy_cyc - req_cyc), 32'd4);
    check("t1_psel", 32'(seen_psel), 32'b10000);
    check("t1_err", 32'(err_rdy), 32'h0);

    // Unmapped index 7
    xfer(1'b0, 32'h1000_7000, 32'h0, 0, 32'h0, 1'b0);
    check("t2_latency", 32'(rdy_cyc - req_cyc), 32'd2);
    check("t2_psel", 32'(seen_psel), 32'h0);
    check("t2_err", 32'(err_rdy), 32'h1);
    check("t2_rdata", rdata_rdy, 32'h0);

    // Slave 1 never ready: timeout
    xfer(1'b0, 32'h1000_1004, 32'h0, -1, 32'h5555_AAAA, 1'b0);
    check("t3_penable_cycles", 32'(pen_cnt), 32'd16);
    check("t3_err", 32'(err_rdy), 32'h1);
    check("t3_rdata", rdata_rdy, 32'h0);
    check("t3_latency", 32'(rdy_cyc - req_cyc), 32'd18);

    // Stray PREADY[3] while slave 0 selected
    xfer(1'b0, 32'h1000_0010, 32'h0, 2, 32'h1234_5678, 1'b1);
    check("t4_latency", 32'(rdy_cyc - req_cyc), 32'd5);
    check("t4_rdata", rdata_rdy, 32'h1234_5678);
    check("t4_psel", 32'(seen_psel), 32'b00001);

    // PREADY on the last allowed ACCESS cycle still succeeds
    xfer(1'b0, 32'h1000_3FFC, 32'h0, 15, 32'hCAFE_F00D, 1'b0);
    check("t5_penable_cycles", 32'(pen_cnt), 32'd16);
    check("t5_err", 32'(err_rdy), 32'h0);
    check("t5_rdata", rdata_rdy, 32'hCAFE_F00D);

    // Store returns zero read data
    xfer(1'b1, 32'h1000_2000, 32'hFFFF_0001, 0, 32'h7777_7777, 1'b0);
    check("t6_rdata", rdata_rdy, 32'h0);

    // Outside the peripheral region
    xfer(1'b0, 32'h2000_1000, 32'h0, 0, 32'h0, 1'b0);
    check("t7_err", 32'(err_rdy), 32'h1);

    // Zero-wait load from slave 2
    xfer(1'b0, 32'h1000_200C, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    check("t8_latency", 32'(rdy_cyc - req_cyc), 32'd3);
    check("t8_rdata", rdata_rdy, 32'hDEAD_BEEF);
    check("t8_psel", 32'(seen_psel), 32'b00100);

    // Asynchronous reset in the middle of ACCESS
    chk_en = 1'b0;
    @(posedge PCLK); #1;
    req = 1'b1; write = 1'b0; addr = 32'h1000_1010; wdata = 32'h0;
    repeat (3) @(posedge PCLK);
    #2;
    check("rst_mid_pre_penable", 32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", 32'(PSEL), 32'h0);
    check("rst_mid_penable", 32'(PENABLE), 32'h0);
    check("rst_mid_ready", 32'(ready), 32'h0);
    check("rst_mid_err", 32'(err), 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    req = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    exp_tbl.delete();
    chk_en = 1'b1;

    xfer(1'b0, 32'h1000_3100, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
    check("t9_rdata", rdata_rdy, 32'h0BAD_CAFE);
    check("t9_latency", 32'(rdy_cyc - req_cyc), 32'd3);

    repeat (2) @(posedge PCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator (bridge) between the multicycle RISC-V core's data-bus port and the APB peripheral slaves: RAM, GPO, GPI, GPIO and UART.
- Takes one CPU load/store request at a time and decodes the address to a one-hot PSEL.
- Runs the APB SETUP/ACCESS sequence, waits for the selected slave's PREADY, then returns read data and a completion pulse to the core.
- Aborts with an error on an unmapped address or a slave timeout.

Parameters:
- NUM_SLAVES, 5, number of APB slaves; slave i occupies window 0x1000_0000 + i*0x1000 (4 KB each).
- TIMEOUT, 16, max ACCESS-phase cycles waiting for PREADY before abort; must be >= 2.

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  reset, asynchronous, active-high.
- req  in  1  CPU transfer request; held high until ready.
- write  in  1  1 = store, 0 = load; valid with req.
- addr  in  32  CPU byte address; valid with req.
- wdata  in  32  store data; valid with req.
- rdata  out  32  load data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  decode/timeout error; valid with ready.
- PADDR  out  32  latched transfer address.
- PWRITE  out  1  latched direction.
- PWDATA  out  32  latched write data.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  32*NUM_SLAVES  slave read data, slave i at bits [32i+31:32i].
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Reset (async, any state, including mid-transfer): state=IDLE; PADDR, PWDATA and rdata=0; PWRITE, PENABLE, PSEL, ready and err all 0; timeout counter=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Decode:
  - hit iff addr[31:16]==16'h1000 and addr[15:12] < NUM_SLAVES; slave index = addr[15:12].
  - addr[11:0] is passed through unchanged in PADDR.
- States: IDLE, SETUP, ACCESS, ERROR.
- IDLE:
  - ready=0, PSEL=0, PENABLE=0.
  - If req=1: latch addr, write, wdata and the decoded index into PADDR, PWRITE, PWDATA and sel.
  - Hit → SETUP. Miss → ERROR.
- SETUP (exactly 1 cycle): PSEL[sel]=1, PENABLE=0 → ACCESS.
- ACCESS:
  - PSEL[sel]=1, PENABLE=1; PADDR, PWRITE and PWDATA are held stable.
  - Counter increments each ACCESS cycle.
  - If PREADY[sel]=1: rdata<=PRDATA[sel] (loads only; stores give rdata=0), ready<=1, err<=0, PSEL and PENABLE cleared, → IDLE.
  - Else if counter==TIMEOUT-1: rdata<=0, ready<=1, err<=1, PSEL and PENABLE cleared, → IDLE.
  - PREADY from non-selected slaves is ignored.
- ERROR (1 cycle): no PSEL asserted; ready<=1, err<=1, rdata<=0 → IDLE.
- The counter clears on every entry to SETUP.
- ready is high for exactly one cycle: the first cycle back in IDLE.
- The requester must drop req in the ready cycle unless it issues a new transfer. If req=1 in that IDLE cycle, a new transfer starts; this gives a minimum of one IDLE cycle between transfers.
- Latency:
  - Zero-wait slave (PREADY high in the first ACCESS cycle): ready 3 cycles after req is sampled.
  - One-cycle registered-PREADY slave: ready 4 cycles after req is sampled.
- Changes to addr, write or wdata after req is sampled have no effect on the current transfer.

Test Plan:
- Store addr=0x1000_4008, wdata=0x0000_0041; slave4 PREADY one cycle after ACCESS → PSEL=5'b10000, PADDR=0x1000_4008, PWRITE=1, PWDATA=0x41; ready pulses once 4 cycles after req; err=0.
- Load addr=0x1000_200C; slave2 PRDATA=0xDEAD_BEEF; PREADY in the first ACCESS cycle → rdata=0xDEAD_BEEF with ready 3 cycles after req; PSEL=5'b00100 during SETUP and ACCESS only.
- Load addr=0x1000_7000 (index 7 ≥ NUM_SLAVES) → PSEL stays 0; ready=1, err=1, rdata=0 two cycles after req.
- Slave1 never asserts PREADY, TIMEOUT=16 → PENABLE high for exactly 16 cycles; then ready=1, err=1, PSEL cleared.
- PREADY[3]=1 while slave0 is selected → ignored, master stays in ACCESS; the following PREADY[0] completes the transfer.
- PRESET asserted during ACCESS → PSEL, PENABLE, ready, err and rdata go to 0 immediately (asynchronously); a fresh req after release completes normally.
